color_seq_fsm: RTL

Parametrised successor to the two-state Color FSM. It is a three-colour Moore sequencer (RED→GREEN→YELLOW→RED) plus a FAULT state.
- Each colour has a per-state dwell timer for timed auto-advance.
- A valid/ready command port provides manual control.
- A hold mode freezes sequencing; FAULT is sticky.
- Sits beside the colour-control datapath as its output-code source.

---
 rtl/color_seq_pkg.sv | 39 +++
 rtl/color_seq_fsm_dwell_timer.sv | 38 +++
 rtl/color_seq_fsm.sv | 134 +++++++++++++
 3 files changed

// File: rtl/color_seq_pkg.sv
// ============================================================================
//  Module      : color_seq_pkg
//  Description : Shared state/command encodings and output codes for the
//                colour sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package color_seq_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FAULT  = 2'd3
  } color_state_t;

  typedef enum logic [1:0] {
    NOP         = 2'd0,
    ADVANCE     = 2'd1,
    HOLD_TOGGLE = 2'd2,
    FORCE_RED   = 2'd3
  } color_cmd_t;

  localparam logic [3:0] c_OUT_RED    = 4'h1;
  localparam logic [3:0] c_OUT_GREEN  = 4'h2;
  localparam logic [3:0] c_OUT_YELLOW = 4'h4;

  function automatic color_state_t next_color(input color_state_t s);
    case (s)
      RED:     next_color = GREEN;
      GREEN:   next_color = YELLOW;
      default: next_color = RED;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/color_seq_fsm_dwell_timer.sv
// ============================================================================
//  Module      : dwell_timer
//  Description : Saturating dwell counter with synchronous clear and a
//                limit comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_timer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 expire
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt != {CNT_WIDTH{1'b1}}) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  // >= rather than == so an overrun (e.g. after hold) still expires
  assign expire = (r_cnt >= (limit - CNT_WIDTH'(1)));
  assign cnt    = r_cnt;

endmodule

`default_nettype wire

// File: rtl/color_seq_fsm.sv
// ============================================================================
//  Module      : color_seq_fsm
//  Description : RED->GREEN->YELLOW Moore sequencer with dwell timing,
//                valid/ready command port, hold mode and sticky FAULT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_seq_fsm
  import color_seq_pkg::*;
#(
  parameter int CMD_WIDTH    = 2,
  parameter int OUT_WIDTH    = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int RED_DWELL    = 8,
  parameter int GREEN_DWELL  = 6,
  parameter int YELLOW_DWELL = 2,
  parameter bit AUTO_MODE    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CMD_WIDTH-1:0] cmd,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 fault_clr,
  output logic [OUT_WIDTH-1:0] out,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] dwell_cnt,
  output logic                 hold_o,
  output logic                 fault
);

  color_state_t         r_state;
  color_state_t         w_next;
  logic                 r_hold;
  logic                 w_hold_next;
  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_restart;
  logic                 w_at_limit;
  logic                 w_expire;
  logic [CNT_WIDTH-1:0] w_limit;
  color_cmd_t           w_cmd;

  assign w_cmd    = color_cmd_t'(cmd[1:0]);
  assign w_accept = cmd_valid && cmd_ready;

  generate
    if (CMD_WIDTH > 2) begin : g_illegal_wide
      assign w_illegal = |cmd[CMD_WIDTH-1:2];
    end else begin : g_illegal_none
      assign w_illegal = 1'b0;
    end
  endgenerate

  always_comb begin
    w_limit = CNT_WIDTH'(RED_DWELL);
    case (r_state)
      GREEN:   w_limit = CNT_WIDTH'(GREEN_DWELL);
      YELLOW:  w_limit = CNT_WIDTH'(YELLOW_DWELL);
      default: w_limit = CNT_WIDTH'(RED_DWELL);
    endcase
  end

  dwell_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_restart),
    .limit  (w_limit),
    .cnt    (dwell_cnt),
    .expire (w_at_limit)
  );

  // Expiry is judged on the current hold value, even when a toggle is accepted
  assign w_expire = AUTO_MODE && !r_hold && w_at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RED;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= w_hold_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_hold_next = r_hold;
    w_restart   = 1'b0;
    case (r_state)
      FAULT: begin
        if (fault_clr) w_next = RED;
      end
      RED, GREEN, YELLOW: begin
        if (w_accept && w_illegal) begin
          w_next      = FAULT;
          w_hold_next = 1'b0;
        end else if (w_accept && w_cmd == FORCE_RED) begin
          w_next    = RED;
          w_restart = 1'b1;
        end else if ((w_accept && w_cmd == ADVANCE) || w_expire) begin
          w_next = next_color(r_state);
        end
        if (w_accept && !w_illegal && w_cmd == HOLD_TOGGLE) w_hold_next = !r_hold;
      end
      default: begin
        w_next      = FAULT;
        w_hold_next = 1'b0;
      end
    endcase
    if (w_next != r_state) w_restart = 1'b1;
  end

  always_comb begin
    out = OUT_WIDTH'(c_OUT_RED);
    case (r_state)
      GREEN:   out = OUT_WIDTH'(c_OUT_GREEN);
      YELLOW:  out = OUT_WIDTH'(c_OUT_YELLOW);
      FAULT:   out = '1;
      default: out = OUT_WIDTH'(c_OUT_RED);
    endcase
  end

  assign state_o   = r_state;
  assign fault     = (r_state == FAULT);
  assign cmd_ready = (r_state != FAULT);
  assign hold_o    = r_hold;

endmodule

`default_nettype wire
